// File: rtl/rcpu_dbg_pkg.sv
// Shared types and sizing helpers for the RCPU board debug monitor.
package rcpu_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } dbg_state_e;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_LED_W  = 8;
  localparam int unsigned PAGE_N     = DEF_DATA_W / DEF_LED_W;
  localparam int unsigned PAGE_W     = (PAGE_N > 1) ? $clog2(PAGE_N) : 1;

  // Number of LED-wide pages in a data word.
  function automatic int unsigned page_n(input int unsigned data_w, input int unsigned led_w);
    return data_w / led_w;
  endfunction

  // Page index width, never narrower than one bit.
  function automatic int unsigned page_w(input int unsigned data_w, input int unsigned led_w);
    int unsigned n;
    n = data_w / led_w;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stable-run debouncer and one-cycle rise strobe for a raw button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      rise    <= level & ~level_q;
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_debug_monitor.sv
// Board debug front end: single-step / free-run CPU enable, channel snapshot and LED paging.
// Optional breakpoint halt is built when RCPU_DBG_BREAKPOINT_EN is defined.
module cpu_debug_monitor
  import rcpu_dbg_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned NUM_CH          = 8,
  parameter int unsigned LED_W           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                step_btn,
  input  logic                                page_btn,
  input  logic                                run_mode,
  input  logic [$clog2(NUM_CH)-1:0]           SW,
  input  logic [NUM_CH*DATA_W-1:0]            ch_data,
  output logic [LED_W-1:0]                    LED,
  output logic                                cpu_en,
  output logic [CNT_W-1:0]                    step_count,
  output logic [page_w(DATA_W, LED_W)-1:0]    page
`ifdef RCPU_DBG_BREAKPOINT_EN
  ,
  input  logic [DATA_W-1:0]                   bp_addr,
  input  logic                                bp_valid,
  output logic                                halted
`endif
);

  localparam int unsigned NPG  = page_n(DATA_W, LED_W);
  localparam int unsigned PGW  = page_w(DATA_W, LED_W);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  dbg_state_e        state;
  dbg_state_e        state_nxt;
  logic              cpu_en_d;
  logic              step_rise;
  logic              page_rise;
  logic              run_s1;
  logic              run_s2;
  logic [CH_W-1:0]   sw_q;
  logic              sw_chg;
  logic              snap_load;
  logic [DATA_W-1:0] snapshot;
  logic [DATA_W-1:0] ch_sel;
  logic [LED_W-1:0]  led_d;
`ifdef RCPU_DBG_BREAKPOINT_EN
  logic              bp_hit;
  logic              halted_d;
  logic              halt_entry;
`endif

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk  (clk),
    .rst  (rst),
    .btn  (step_btn),
    .rise (step_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_page_db (
    .clk  (clk),
    .rst  (rst),
    .btn  (page_btn),
    .rise (page_rise)
  );

`ifdef RCPU_DBG_BREAKPOINT_EN
  assign bp_hit = bp_valid && (ch_data[DATA_W-1:0] == bp_addr);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: run_mode wins over a coincident step rise.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (run_s2) begin
          state_nxt = RUN;
        end else if (step_rise) begin
          state_nxt = STEP;
        end
      end
      STEP: state_nxt = IDLE;
      RUN: begin
        if (!run_s2) begin
          state_nxt = IDLE;
`ifdef RCPU_DBG_BREAKPOINT_EN
        end else if (bp_hit) begin
          state_nxt = HALT;
`endif
        end
      end
`ifdef RCPU_DBG_BREAKPOINT_EN
      HALT: begin
        if (!run_s2) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state so registered outputs line up with the state.
  always_comb begin
    cpu_en_d   = (state_nxt == STEP) || (state_nxt == RUN);
`ifdef RCPU_DBG_BREAKPOINT_EN
    halted_d   = (state_nxt == HALT);
    halt_entry = (state_nxt == HALT) && (state != HALT);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_en <= 1'b0;
`ifdef RCPU_DBG_BREAKPOINT_EN
      halted <= 1'b0;
`endif
    end else begin
      cpu_en <= cpu_en_d;
`ifdef RCPU_DBG_BREAKPOINT_EN
      halted <= halted_d;
`endif
    end
  end

  // Channel select mux.
  always_comb begin
    ch_sel = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (SW == CH_W'(k)) begin
        ch_sel = ch_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // LED page mux over the captured snapshot.
  always_comb begin
    led_d = '0;
    for (int unsigned p = 0; p < NPG; p++) begin
      if (page == PGW'(p)) begin
        led_d = snapshot[p*LED_W +: LED_W];
      end
    end
  end

  assign sw_chg = (SW != sw_q);
`ifdef RCPU_DBG_BREAKPOINT_EN
  assign snap_load = cpu_en | sw_chg | halt_entry;
`else
  assign snap_load = cpu_en | sw_chg;
`endif

  // Run-mode sync, step counter, snapshot, paging and LED register.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_s1     <= 1'b0;
      run_s2     <= 1'b0;
      sw_q       <= '0;
      step_count <= '0;
      snapshot   <= '0;
      page       <= '0;
      LED        <= '0;
    end else begin
      run_s1 <= run_mode;
      run_s2 <= run_s1;
      sw_q   <= SW;
      if (cpu_en && (step_count != '1)) begin
        step_count <= step_count + CNT_W'(1);
      end
      if (snap_load) begin
        snapshot <= ch_sel;
      end
      if (sw_chg) begin
        page <= '0;
      end else if (page_rise) begin
        if (page == PGW'(NPG - 1)) begin
          page <= '0;
        end else begin
          page <= page + PGW'(1);
        end
      end
      LED <= led_d;
    end
  end

endmodule

// File: tb/tb_cpu_debug_monitor.sv
// Randomised plus directed bench for cpu_debug_monitor against a behavioural reference model.
module tb_cpu_debug_monitor;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NUM_CH = 8;
  localparam int unsigned LED_W  = 8;
  localparam int unsigned DEB    = 4;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned NPG    = DATA_W / LED_W;
  localparam int unsigned PGW    = 2;
  localparam int unsigned CH_W   = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     step_btn;
  logic                     page_btn;
  logic                     run_mode;
  logic [CH_W-1:0]          SW;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [LED_W-1:0]         LED;
  logic                     cpu_en;
  logic [CNT_W-1:0]         step_count;
  logic [PGW-1:0]           page;
`ifdef RCPU_DBG_BREAKPOINT_EN
  logic [DATA_W-1:0]        bp_addr;
  logic                     bp_valid;
  logic                     halted;
`endif

  always #5 clk = ~clk;

  cpu_debug_monitor #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .LED_W(LED_W),
    .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .step_btn(step_btn), .page_btn(page_btn),
    .run_mode(run_mode), .SW(SW), .ch_data(ch_data), .LED(LED),
    .cpu_en(cpu_en), .step_count(step_count), .page(page)
`ifdef RCPU_DBG_BREAKPOINT_EN
    , .bp_addr(bp_addr), .bp_valid(bp_valid), .halted(halted)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: inputs are seen two cycles late, a level is accepted after DEB
  // agreeing samples, and the rise strobe appears one cycle after acceptance.
  localparam int M_IDLE = 0, M_STEP = 1, M_RUN = 2, M_HALT = 3;
  logic [1:0]        m_hs, m_hp, m_hr;
  logic              m_sl, m_sl_old, m_sr;
  logic              m_pl, m_pl_old, m_pr;
  int                m_sd, m_pd;
  int                m_st;
  logic              m_en, m_halt;
  int                m_cnt;
  logic [DATA_W-1:0] m_snap;
  int                m_page;
  logic [LED_W-1:0]  m_led;
  logic [CH_W-1:0]   m_sw;

  int   en_cycles, en_pulses;
  logic prev_en;

  task automatic deb(input logic s, inout logic lvl, inout int diff);
    if (s != lvl) begin
      diff++;
      if (diff >= int'(DEB)) begin
        lvl  = s;
        diff = 0;
      end
    end else begin
      diff = 0;
    end
  endtask

  function automatic bit bp_now();
`ifdef RCPU_DBG_BREAKPOINT_EN
    return bp_valid && (ch_data[DATA_W-1:0] == bp_addr);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    logic rs;
    int nst;
    bit sw_chg;
    logic [DATA_W-1:0] chv;
    if (rst) begin
      m_hs = 0; m_hp = 0; m_hr = 0;
      m_sl = 0; m_sl_old = 0; m_sr = 0; m_sd = 0;
      m_pl = 0; m_pl_old = 0; m_pr = 0; m_pd = 0;
      m_st = M_IDLE; m_en = 0; m_halt = 0; m_cnt = 0;
      m_snap = 0; m_page = 0; m_led = 0; m_sw = 0;
      return;
    end
    rs  = m_hr[1];
    nst = m_st;
    case (m_st)
      M_IDLE: if (rs) nst = M_RUN; else if (m_sr) nst = M_STEP;
      M_STEP: nst = M_IDLE;
      M_RUN:  if (!rs) nst = M_IDLE; else if (bp_now()) nst = M_HALT;
      default: if (!rs) nst = M_IDLE;
    endcase
    sw_chg = (SW != m_sw);
    chv    = ch_data[int'(SW)*DATA_W +: DATA_W];
    m_led  = m_snap[m_page*LED_W +: LED_W];
    if (m_en || sw_chg || (nst == M_HALT && m_st != M_HALT)) m_snap = chv;
    if (m_en && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    if (sw_chg) m_page = 0;
    else if (m_pr) m_page = (m_page + 1) % int'(NPG);
    m_en   = (nst == M_STEP) || (nst == M_RUN);
    m_halt = (nst == M_HALT);
    m_st   = nst;
    m_sw   = SW;
    m_sr = m_sl && !m_sl_old; m_sl_old = m_sl; deb(m_hs[1], m_sl, m_sd);
    m_pr = m_pl && !m_pl_old; m_pl_old = m_pl; deb(m_hp[1], m_pl, m_pd);
    m_hs = {m_hs[0], step_btn};
    m_hp = {m_hp[0], page_btn};
    m_hr = {m_hr[0], run_mode};
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("cpu_en", 64'(cpu_en), 64'(m_en));
    check("step_count", 64'(step_count), 64'(m_cnt));
    check("page", 64'(page), 64'(m_page));
    check("led", 64'(LED), 64'(m_led));
`ifdef RCPU_DBG_BREAKPOINT_EN
    check("halted", 64'(halted), 64'(m_halt));
`endif
    if (cpu_en) en_cycles++;
    if (cpu_en && !prev_en) en_pulses++;
    prev_en = cpu_en;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_step(input int hold);
    step_btn = 1'b1; ticks(hold);
    step_btn = 1'b0; ticks(hold);
  endtask

  task automatic press_page();
    page_btn = 1'b1; ticks(8);
    page_btn = 1'b0; ticks(10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [LED_W-1:0] exp_led [5];
    exp_led = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'hD4};
    en_cycles = 0; en_pulses = 0; prev_en = 1'b0;
    rst = 1'b1; step_btn = 1'b0; page_btn = 1'b0; run_mode = 1'b0; SW = '0;
    for (int k = 0; k < int'(NUM_CH); k++) ch_data[k*DATA_W +: DATA_W] = $urandom();
`ifdef RCPU_DBG_BREAKPOINT_EN
    bp_addr = '0; bp_valid = 1'b0;
`endif
    ticks(3);
    check("rst_led", 64'(LED), 64'h0);
    check("rst_cpu_en", 64'(cpu_en), 64'h0);
    check("rst_page", 64'(page), 64'h0);
    rst = 1'b0;
    ticks(2);

    // Bouncy step press gives one single-cycle enable.
    en_cycles = 0; en_pulses = 0;
    step_btn = 1'b1; tick(); step_btn = 1'b0; tick();
    step_btn = 1'b1; tick(); step_btn = 1'b0; tick();
    step_btn = 1'b1; ticks(10); step_btn = 1'b0; ticks(12);
    check("bounce_pulses", 64'(en_pulses), 64'd1);
    check("bounce_len", 64'(en_cycles), 64'd1);
    check("bounce_count", 64'(step_count), 64'd1);

    // Paging through a known word.
    ch_data[2*DATA_W +: DATA_W] = 32'hA1B2C3D4;
    SW = 3'd2;
    ticks(3);
    press_step(8);
    ticks(4);
    check("page_led0", 64'(LED), 64'(exp_led[0]));
    for (int i = 1; i < 5; i++) begin
      press_page();
      check($sformatf("page_led%0d", i), 64'(LED), 64'(exp_led[i]));
    end
    check("page_wrap", 64'(page), 64'd0);

    // Free run for 20 cycles with an ignored step press inside.
    en_cycles = 0; en_pulses = 0;
    run_mode = 1'b1; ticks(5);
    step_btn = 1'b1; ticks(8);
    step_btn = 1'b0; ticks(7);
    run_mode = 1'b0; ticks(20);
    check("run_len", 64'(en_cycles), 64'd20);
    check("run_pulses", 64'(en_pulses), 64'd1);
    check("run_count", 64'(step_count), 64'd22);

    // Counter saturation.
    run_mode = 1'b1; ticks(70);
    run_mode = 1'b0; ticks(10);
    check("sat_count", 64'(step_count), 64'h3F);

    // Reset in the middle of a run with page 3 shown.
    for (int i = 0; i < 3; i++) press_page();
    check("pre_rst_page", 64'(page), 64'd3);
    run_mode = 1'b1; ticks(10);
    rst = 1'b1; run_mode = 1'b0; tick();
    check("mid_rst_cpu_en", 64'(cpu_en), 64'h0);
    check("mid_rst_led", 64'(LED), 64'h0);
    check("mid_rst_page", 64'(page), 64'h0);
    check("mid_rst_count", 64'(step_count), 64'h0);
    rst = 1'b0; ticks(5);

`ifdef RCPU_DBG_BREAKPOINT_EN
    begin
      bit seen;
      seen = 1'b0;
      ch_data[DATA_W-1:0] = '0;
      bp_addr = 32'h10; bp_valid = 1'b1; run_mode = 1'b1;
      for (int i = 0; i < 40 && !seen; i++) begin
        tick();
        if (m_st == M_RUN) ch_data[DATA_W-1:0] = ch_data[DATA_W-1:0] + 32'd4;
        seen = halted;
      end
      check("bp_halted", 64'(halted), 64'd1);
      check("bp_cpu_en", 64'(cpu_en), 64'd0);
      press_step(8);
      check("bp_step_ignored", 64'(halted), 64'd1);
      run_mode = 1'b0; bp_valid = 1'b0; ticks(6);
      check("bp_release", 64'(halted), 64'd0);
    end
`endif

    // Randomised traffic checked every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 6) step_btn = ~step_btn;
      if ($urandom_range(0, 99) < 6) page_btn = ~page_btn;
      if ($urandom_range(0, 99) < 2) run_mode = ~run_mode;
      if ($urandom_range(0, 99) < 2) SW = CH_W'($urandom_range(0, NUM_CH - 1));
      if ($urandom_range(0, 99) < 20)
        ch_data[$urandom_range(0, NUM_CH - 1)*DATA_W +: DATA_W] = $urandom();
      rst = ($urandom_range(0, 999) < 2);
`ifdef RCPU_DBG_BREAKPOINT_EN
      bp_valid = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 10) bp_addr = ch_data[DATA_W-1:0];
`endif
      tick();
    end
    rst = 1'b0;
    ticks(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
